fft_sample_feeder: RTL and testbench
====================================

# fft_sample_feeder

Host-side counterpart of the FFT AXI-style bridge. Streams a frame of N samples from a synchronous-read source RAM onto the bridge's sample channel (ARVALID/ARREADY/ARDATA). It then accepts the N result words from the bridge's result channel (AWVALID/AWREADY/AWDATA) and writes them into a result RAM. It sits between the test/host memory subsystem and the FFT bridge, and provides the frame-level start/done control for the whole FFT datapath.

## Interface
- DATA_WIDTH, 32, sample and result word width
- TIMEOUT_CYCLES, 65535, idle-cycle limit for the watchdog (only used with FEEDER_TIMEOUT_EN)
- i_clk  in  1  single clock, all logic on rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_START  in  1  frame start request; sampled only in IDLE
- i_SAMPLES_NUMBER  in  12  frame length N; latched when start is accepted
- o_SRC_RD  out  1  source RAM read strobe
- o_SRC_ADDR  out  12  source RAM address
- i_SRC_DATA  in  DATA_WIDTH  source RAM read data, valid one cycle after o_SRC_RD
- o_ARVALID  out  1  sample valid toward bridge
- o_ARDATA  out  DATA_WIDTH  sample word
- i_ARREADY  in  1  bridge accepts sample
- i_AWVALID  in  1  result valid from bridge
- i_AWDATA  in  DATA_WIDTH  result word
- o_AWREADY  out  1  feeder accepts result
- o_RES_WE, o_RES_ADDR[11:0], o_RES_DATA[DATA_WIDTH-1:0]  out  result RAM write port
- o_BUSY  out  1  high from accepted start until DONE
- o_DONE  out  1  one-cycle pulse when the frame is complete
- o_TIMEOUT  out  1  sticky watchdog flag; cleared by the next accepted start
- current_state  out  enum  FSM state, for debug

## Operation
- Reset values: every output is 0, current_state = IDLE, and all counters and the buffer are empty.
- Transfer rule: a transfer occurs on a rising edge where VALID && READY. o_ARVALID and o_ARDATA must not change while o_ARVALID=1 && i_ARREADY=0.
- States:
  - IDLE → FEED on i_START with N≠0. Latch N, clear the read, sent and result counters, and clear o_TIMEOUT. A start with N=0 is ignored.
  - FEED: issue source reads for addresses 0..N-1 into the 2-entry buffer (sub-module). A read is issued only when buffer occupancy plus in-flight reads is less than 2. o_ARVALID = buffer not empty, o_ARDATA = buffer head. → COLLECT on the edge that transfers sample N-1.
  - COLLECT: o_AWREADY=1. Each result transfer k (0..N-1) produces o_RES_WE=1, o_RES_ADDR=k and o_RES_DATA=AWDATA in the following cycle (registered). → DONE on the edge that transfers result N-1.
  - DONE: o_DONE=1 for one cycle, and o_BUSY drops in the same cycle. → IDLE.
- Results arriving while in FEED are not accepted (o_AWREADY=0).
- i_START outside IDLE is ignored. Asserting i_rstn low in any state immediately returns all outputs to their reset values, and the frame is discarded.
- Counters are 12 bits. Terminal comparisons use N-1 with N latched, so N=4095 is the maximum. No counter wraps within a frame.

## Timing
- Start accepted at edge E0. o_SRC_RD=1 with addr 0 in cycle E0..E1. Data is captured into the buffer at E2. o_ARVALID is first high after E2.
- Sustained throughput is 1 sample/cycle while i_ARREADY=1. The buffer absorbs the one-cycle read latency, so a deassertion of i_ARREADY loses no data.
- The result RAM write lags its handshake by exactly 1 cycle. o_DONE is asserted in the cycle after the last result handshake, coincident with the final o_RES_WE.

## Configuration
- FEEDER_TIMEOUT_EN:
  - Defined: a watchdog counts consecutive cycles in FEED or COLLECT without any transfer. When the count reaches TIMEOUT_CYCLES, set o_TIMEOUT, flush the buffer and return to IDLE without o_DONE.
  - Undefined: no watchdog, o_TIMEOUT is tied 0, and the feeder waits indefinitely.

## Structure
- Shared package fft_feeder_pkg holds the state enum fft_feeder_fsm {IDLE, FEED, COLLECT, DONE} and the 12-bit index width constant.
- One sub-module, fft_feed_skid: a 2-entry FIFO with push, pop, head, empty and count.

## Test plan
- N=8, i_ARREADY and i_AWVALID held high, source RAM = 0..7 → samples 0..7 appear on consecutive cycles; results 100..107 are written to addresses 0..7; one o_DONE pulse.
- N=8, i_ARREADY toggling 1,0,0,1,… → ARDATA is held stable during stalls; no sample is lost or duplicated; order is 0..7.
- N=1 → exactly one AR transfer and one result write to address 0, then DONE.
- i_START with N=0, and i_START pulsed mid-FEED → both ignored; o_BUSY unaffected.
- i_rstn asserted after 3 samples → all outputs are 0 asynchronously; a fresh N=4 start afterwards completes normally.
- FEEDER_TIMEOUT_EN defined with TIMEOUT_CYCLES=16 and i_AWVALID never asserted → o_TIMEOUT=1 after 16 idle COLLECT cycles; state returns to IDLE; no o_DONE.

Source files
------------

// File: rtl/fft_feeder_pkg.sv
// fft_feeder_pkg: shared types and constants for the FFT sample feeder.
//   IDX_W          - width of sample/result indices and frame length
//   idx_t          - index type
//   fft_feeder_fsm - feeder frame state
//   last_idx()     - terminal index of a frame of length n
package fft_feeder_pkg;

  localparam int IDX_W = 12;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FEED    = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } fft_feeder_fsm;

  function automatic idx_t last_idx(input idx_t n);
    return n - idx_t'(1);
  endfunction

endpackage

// File: rtl/fft_feed_skid.sv
// fft_feed_skid: 2-entry FIFO that absorbs the source RAM read latency.
//   i_clk, i_rstn    - clock, asynchronous active-low reset
//   i_flush          - empty the FIFO (wins over push/pop)
//   i_push, i_din    - write an entry
//   i_pop            - drop the head entry (ignored when empty)
//   o_head           - current head entry, stable until popped
//   o_empty, o_count - occupancy
module fft_feed_skid #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_pop;
  logic         w_push;

  assign w_pop   = i_pop && r_cnt != 2'd0;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_push  = i_push && (r_cnt != 2'd2 || w_pop);
  assign o_head  = r_mem[r_rp];
  assign o_empty = r_cnt == 2'd0;
  assign o_count = r_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_flush) begin
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (w_pop)
        r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/fft_sample_feeder.sv
// fft_sample_feeder: streams N samples from a source RAM to the FFT bridge and
// writes the N returned results into a result RAM.
//   i_clk, i_rstn                     - clock, asynchronous active-low reset
//   i_START, i_SAMPLES_NUMBER         - frame start and length N (N=0 ignored)
//   o_SRC_RD, o_SRC_ADDR, i_SRC_DATA  - source RAM, data one cycle after read
//   o_ARVALID, o_ARDATA, i_ARREADY    - sample channel to the bridge
//   i_AWVALID, i_AWDATA, o_AWREADY    - result channel from the bridge
//   o_RES_WE, o_RES_ADDR, o_RES_DATA  - result RAM write port
//   o_BUSY, o_DONE, o_TIMEOUT         - frame status
//   current_state                     - FSM state for debug
// Optional feature: define FEEDER_TIMEOUT_EN to enable the idle watchdog
// (TIMEOUT_CYCLES consecutive cycles without a transfer aborts the frame).
module fft_sample_feeder
  import fft_feeder_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_START,
  input  logic [IDX_W-1:0]      i_SAMPLES_NUMBER,
  output logic                  o_SRC_RD,
  output logic [IDX_W-1:0]      o_SRC_ADDR,
  input  logic [DATA_WIDTH-1:0] i_SRC_DATA,
  output logic                  o_ARVALID,
  output logic [DATA_WIDTH-1:0] o_ARDATA,
  input  logic                  i_ARREADY,
  input  logic                  i_AWVALID,
  input  logic [DATA_WIDTH-1:0] i_AWDATA,
  output logic                  o_AWREADY,
  output logic                  o_RES_WE,
  output logic [IDX_W-1:0]      o_RES_ADDR,
  output logic [DATA_WIDTH-1:0] o_RES_DATA,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_TIMEOUT,
  output fft_feeder_fsm         current_state
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  fft_feeder_fsm         r_state;
  fft_feeder_fsm         w_next;
  idx_t                  r_n;
  idx_t                  r_rd_cnt;
  idx_t                  r_sent;
  idx_t                  r_res_cnt;
  logic                  r_inflight;
  logic                  r_res_we;
  idx_t                  r_res_addr;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  w_start;
  logic                  w_rd;
  logic                  w_ar_xfer;
  logic                  w_aw_xfer;
  logic                  w_to;
  logic                  w_empty;
  logic [1:0]            w_count;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_start   = r_state == IDLE && i_START && i_SAMPLES_NUMBER != '0;
  assign w_ar_xfer = o_ARVALID && i_ARREADY;
  assign w_aw_xfer = i_AWVALID && o_AWREADY;

  // Occupancy is taken after this cycle's pop so that a draining buffer can be
  // refilled every cycle; without that the feed would drop to one sample per
  // two cycles.
  assign w_rd = r_state == FEED && r_rd_cnt != r_n &&
                ({1'b0, w_count} - {2'b0, w_ar_xfer} + {2'b0, r_inflight}) < 3'd2;

  assign o_SRC_RD      = w_rd;
  assign o_SRC_ADDR    = w_rd ? r_rd_cnt : '0;
  assign o_ARVALID     = !w_empty;
  assign o_ARDATA      = w_head;
  assign o_AWREADY     = r_state == COLLECT;
  assign o_RES_WE      = r_res_we;
  assign o_RES_ADDR    = r_res_addr;
  assign o_RES_DATA    = r_res_data;
  assign o_BUSY        = r_state == FEED || r_state == COLLECT;
  assign o_DONE        = r_state == DONE;
  assign current_state = r_state;

  fft_feed_skid #(.W(DATA_WIDTH)) u_skid (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_flush (w_to),
    .i_push  (r_inflight),
    .i_din   (i_SRC_DATA),
    .i_pop   (w_ar_xfer),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb
    w_next = w_to                                                        ? IDLE    :
             w_start                                                     ? FEED    :
             r_state == FEED && w_ar_xfer && r_sent == last_idx(r_n)     ? COLLECT :
             r_state == COLLECT && w_aw_xfer && r_res_cnt == last_idx(r_n) ? DONE  :
             r_state == DONE                                             ? IDLE    :
                                                                           r_state;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= IDLE;
      r_n        <= '0;
      r_rd_cnt   <= '0;
      r_sent     <= '0;
      r_res_cnt  <= '0;
      r_inflight <= 1'b0;
      r_res_we   <= 1'b0;
      r_res_addr <= '0;
      r_res_data <= '0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_rd && !w_to;
      r_res_we   <= w_aw_xfer;
      if (w_aw_xfer) begin
        r_res_addr <= r_res_cnt;
        r_res_data <= i_AWDATA;
      end
      if (w_start) begin
        r_n       <= i_SAMPLES_NUMBER;
        r_rd_cnt  <= '0;
        r_sent    <= '0;
        r_res_cnt <= '0;
      end else begin
        if (w_rd)
          r_rd_cnt <= r_rd_cnt + idx_t'(1);
        if (w_ar_xfer)
          r_sent <= r_sent + idx_t'(1);
        if (w_aw_xfer)
          r_res_cnt <= r_res_cnt + idx_t'(1);
      end
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_timeout;
  logic            w_idle;

  // A busy cycle with no handshake on either channel.
  assign w_idle    = o_BUSY && !w_ar_xfer && !w_aw_xfer;
  assign w_to      = w_idle && r_wd == WD_W'(TIMEOUT_CYCLES - 1);
  assign o_TIMEOUT = r_timeout;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd      <= w_idle && !w_to ? r_wd + WD_W'(1) : '0;
      r_timeout <= w_to ? 1'b1 : w_start ? 1'b0 : r_timeout;
    end
  end
`else
  assign w_to      = 1'b0;
  assign o_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_fft_sample_feeder.sv
// tb_fft_sample_feeder: self-checking bench for fft_sample_feeder.
module tb_fft_sample_feeder;
  import fft_feeder_pkg::*;

  typedef struct {
    int          n;
    int          ar_mode;
    int          aw_mode;
    int          src_kind;
    bit          mid_start;
    logic [31:0] base;
    int          exp_first_av;
    int          exp_done;
  } frame_vec_t;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b1;
  logic          i_START = 1'b0;
  logic [11:0]   i_SAMPLES_NUMBER = '0;
  logic          o_SRC_RD;
  logic [11:0]   o_SRC_ADDR;
  logic [31:0]   i_SRC_DATA = '0;
  logic          o_ARVALID;
  logic [31:0]   o_ARDATA;
  logic          i_ARREADY = 1'b0;
  logic          i_AWVALID = 1'b0;
  logic [31:0]   i_AWDATA = '0;
  logic          o_AWREADY;
  logic          o_RES_WE;
  logic [11:0]   o_RES_ADDR;
  logic [31:0]   o_RES_DATA;
  logic          o_BUSY;
  logic          o_DONE;
  logic          o_TIMEOUT;
  fft_feeder_fsm current_state;

  logic [31:0] src_mem [4096];
  int checks = 0;
  int errors = 0;

  fft_sample_feeder #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .i_clk            (i_clk),
    .i_rstn           (i_rstn),
    .i_START          (i_START),
    .i_SAMPLES_NUMBER (i_SAMPLES_NUMBER),
    .o_SRC_RD         (o_SRC_RD),
    .o_SRC_ADDR       (o_SRC_ADDR),
    .i_SRC_DATA       (i_SRC_DATA),
    .o_ARVALID        (o_ARVALID),
    .o_ARDATA         (o_ARDATA),
    .i_ARREADY        (i_ARREADY),
    .i_AWVALID        (i_AWVALID),
    .i_AWDATA         (i_AWDATA),
    .o_AWREADY        (o_AWREADY),
    .o_RES_WE         (o_RES_WE),
    .o_RES_ADDR       (o_RES_ADDR),
    .o_RES_DATA       (o_RES_DATA),
    .o_BUSY           (o_BUSY),
    .o_DONE           (o_DONE),
    .o_TIMEOUT        (o_TIMEOUT),
    .current_state    (current_state)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous-read source RAM.
  always @(posedge i_clk)
    if (o_SRC_RD)
      i_SRC_DATA <= src_mem[o_SRC_ADDR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_outs"}, {o_SRC_RD, o_SRC_ADDR, o_ARVALID, o_AWREADY, o_RES_WE, o_RES_ADDR,
                          o_BUSY, o_DONE, o_TIMEOUT}, '0);
    chk({name, "_data"}, {o_ARDATA, o_RES_DATA}, '0);
    chk({name, "_state"}, current_state, IDLE);
  endtask

  function automatic bit rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c - 1) % 3 == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic start_pulse(input int n);
    @(posedge i_clk); #1;
    i_START = 1'b1;
    i_SAMPLES_NUMBER = 12'(n);
    @(posedge i_clk); #1;
    i_START = 1'b0;
  endtask

  // Runs one frame against a model: samples must equal src_mem[0..n-1] in order,
  // result k must be written as (k, base+k) one cycle after its handshake, and
  // DONE must coincide with the last write.
  task automatic run_frame(input frame_vec_t v, input int abort_after);
    logic [31:0] exp_ar [$];
    logic [31:0] prev_data = '0;
    int ar_got = 0, wr_got = 0, hs = 0, rd_next = 0, done_cnt = 0, cyc = 0;
    int first_av = -1, first_tr = -1, last_tr = -1;
    bit prev_stall = 0, prev_hs = 0, finished = 0, cur_hs;
    for (int i = 0; i < v.n; i++) begin
      src_mem[i] = v.src_kind == 0 ? 32'(i) : $urandom;
      exp_ar.push_back(src_mem[i]);
    end
    i_ARREADY = rdy(v.ar_mode, 1);
    i_AWVALID = rdy(v.aw_mode, 1);
    i_AWDATA  = v.base;
    start_pulse(v.n);
    while (!finished && cyc < 4 * v.n + 50) begin
      @(negedge i_clk);
      cyc++;
      chk("busy", o_BUSY, hs < v.n);
      chk("done", o_DONE, hs == v.n);
      chk("awready", o_AWREADY, ar_got == v.n && hs < v.n);
      chk("timeout_low", o_TIMEOUT, 0);
      chk("res_we_lag", o_RES_WE, prev_hs);
      if (o_SRC_RD) begin
        chk("src_addr", o_SRC_ADDR, rd_next);
        rd_next++;
      end
      if (prev_stall) begin
        chk("ar_hold_valid", o_ARVALID, 1);
        chk("ar_hold_data", o_ARDATA, prev_data);
      end
      if (o_ARVALID && first_av < 0) first_av = cyc;
      if (o_ARVALID && i_ARREADY) begin
        chk("ar_data", o_ARDATA, ar_got < v.n ? {32'b0, exp_ar[ar_got]} : 64'hdead_0000_0000);
        ar_got++;
        if (first_tr < 0) first_tr = cyc;
        last_tr = cyc;
      end
      if (o_RES_WE) begin
        chk("res_addr", o_RES_ADDR, wr_got);
        chk("res_data", o_RES_DATA, v.base + 32'(wr_got));
        wr_got++;
      end
      if (o_DONE) done_cnt++;
      finished = hs == v.n;
      cur_hs = i_AWVALID && o_AWREADY;
      if (cur_hs) hs++;
      prev_stall = o_ARVALID && !i_ARREADY;
      prev_data = o_ARDATA;
      prev_hs = cur_hs;
      if (abort_after > 0 && ar_got == abort_after) begin
        #2 i_rstn = 1'b0;
        #1 chk_all_zero("async_reset");
        i_ARREADY = 1'b0;
        i_AWVALID = 1'b0;
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        return;
      end
      @(posedge i_clk); #1;
      i_ARREADY = rdy(v.ar_mode, cyc + 1);
      i_AWVALID = rdy(v.aw_mode, cyc + 1);
      i_AWDATA  = v.base + 32'(hs);
      if (v.mid_start) begin
        i_START = cyc == 4;
        i_SAMPLES_NUMBER = cyc == 4 ? 12'd3 : 12'(v.n);
      end
    end
    chk("frame_complete", finished, 1);
    chk("ar_count", ar_got, v.n);
    chk("wr_count", wr_got, v.n);
    chk("read_count", rd_next, v.n);
    chk("done_count", done_cnt, v.exp_done);
    chk("first_arvalid_cycle", first_av, v.exp_first_av);
    if (v.ar_mode == 0) chk("ar_back_to_back", last_tr - first_tr, v.n - 1);
    i_ARREADY = 1'b0;
    i_AWVALID = 1'b0;
    @(negedge i_clk);
    chk("post_state", current_state, IDLE);
    chk("post_done", {o_DONE, o_BUSY, o_RES_WE}, 0);
  endtask

  frame_vec_t vecs [8];

  initial begin
    vecs[0] = '{n: 8,    ar_mode: 0, aw_mode: 0, src_kind: 0, mid_start: 0, base: 32'd100, exp_first_av: 3, exp_done: 1};
    vecs[1] = '{n: 8,    ar_mode: 1, aw_mode: 0, src_kind: 0, mid_start: 0, base: 32'd100, exp_first_av: 3, exp_done: 1};
    vecs[2] = '{n: 1,    ar_mode: 0, aw_mode: 0, src_kind: 1, mid_start: 0, base: 32'd500, exp_first_av: 3, exp_done: 1};
    vecs[3] = '{n: 8,    ar_mode: 0, aw_mode: 0, src_kind: 1, mid_start: 1, base: $urandom, exp_first_av: 3, exp_done: 1};
    vecs[4] = '{n: 20,   ar_mode: 2, aw_mode: 2, src_kind: 1, mid_start: 0, base: $urandom, exp_first_av: 3, exp_done: 1};
    vecs[5] = '{n: 37,   ar_mode: 2, aw_mode: 2, src_kind: 1, mid_start: 0, base: $urandom, exp_first_av: 3, exp_done: 1};
    vecs[6] = '{n: 2,    ar_mode: 1, aw_mode: 2, src_kind: 1, mid_start: 0, base: $urandom, exp_first_av: 3, exp_done: 1};
    vecs[7] = '{n: 4095, ar_mode: 0, aw_mode: 0, src_kind: 1, mid_start: 0, base: $urandom, exp_first_av: 3, exp_done: 1};

    #3 i_rstn = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 1'b1;

    // Start with N=0 must be ignored.
    start_pulse(0);
    repeat (3) begin
      @(negedge i_clk);
      chk("n0_ignored", {o_BUSY, o_SRC_RD, o_DONE}, 0);
      chk("n0_state", current_state, IDLE);
    end

    for (int i = 0; i < 8; i++)
      run_frame(vecs[i], 0);

    // Asynchronous reset after three samples, then a clean N=4 frame.
    run_frame(vecs[0], 3);
    run_frame('{n: 4, ar_mode: 0, aw_mode: 0, src_kind: 1, mid_start: 0, base: $urandom, exp_first_av: 3, exp_done: 1}, 0);

`ifdef FEEDER_TIMEOUT_EN
    begin
      int coll = 0;
      bit seen_done = 0;
      i_ARREADY = 1'b1;
      i_AWVALID = 1'b0;
      start_pulse(2);
      for (int c = 0; c < 200 && !o_TIMEOUT; c++) begin
        @(negedge i_clk);
        if (current_state == COLLECT) coll++;
        if (o_DONE) seen_done = 1;
      end
      chk("to_flag", o_TIMEOUT, 1);
      chk("to_collect_cycles", coll, 16);
      chk("to_state", current_state, IDLE);
      chk("to_busy", o_BUSY, 0);
      chk("to_no_done", seen_done, 0);
      i_ARREADY = 1'b0;
      run_frame('{n: 3, ar_mode: 0, aw_mode: 0, src_kind: 1, mid_start: 0, base: $urandom, exp_first_av: 3, exp_done: 1}, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
